// File: rtl/psk_serializer.sv
// PSK bit serializer: pops FIFO words and shifts BITS_PER_SYMBOL bits of each onto pwm.
// Optional macro PSK_DIFF_ENCODE_EN: pwm carries differentially encoded data.
module psk_serializer #(
    parameter int SAMPLE_WIDTH    = 8,
    parameter int BITS_PER_SYMBOL = 8,
    parameter int CLK_DIV_WIDTH   = 16,
    parameter int MSB_FIRST       = 0,
    parameter int IDLE_LEVEL      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [CLK_DIV_WIDTH-1:0] clks_per_bit,
    input  logic [SAMPLE_WIDTH-1:0]  sample,
    input  logic                     empty,
    output logic                     read,
    output logic                     pwm,
    output logic                     symb_clk,
    output logic                     busy,
    output logic                     underrun
);

    localparam int BIT_CNT_WIDTH = $clog2(BITS_PER_SYMBOL) + 1;
    localparam logic IDLE_BIT = 1'(IDLE_LEVEL);
    localparam logic [CLK_DIV_WIDTH-1:0] DIV_ONE = CLK_DIV_WIDTH'(1);
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(BITS_PER_SYMBOL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } state_t;

    state_t                   state;
    logic [SAMPLE_WIDTH-1:0]  shift_reg;
    logic [SAMPLE_WIDTH-1:0]  shift_next;
    logic [CLK_DIV_WIDTH-1:0] div;
    logic [CLK_DIV_WIDTH-1:0] div_load;
    logic [CLK_DIV_WIDTH-1:0] clk_cnt;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;
    logic                     bit_end;
    logic                     sym_end;
    logic                     load;
    logic                     next_bit;
    logic                     pwm_bit;
    logic                     idle_out;

    function automatic logic out_bit(input logic [SAMPLE_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[SAMPLE_WIDTH-1] : v[0];
    endfunction

    always_comb begin
        bit_end    = (clk_cnt == div - DIV_ONE);
        sym_end    = bit_end && (bit_cnt == LAST_BIT);
        // A load happens from IDLE or directly at the end of a symbol, so no gap cycle
        load       = enable && !empty && ((state == IDLE) || ((state == RUN) && sym_end));
        div_load   = (clks_per_bit == '0) ? DIV_ONE : clks_per_bit;
        shift_next = (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);
        next_bit   = load ? out_bit(sample) : out_bit(shift_next);
    end

`ifdef PSK_DIFF_ENCODE_EN
    logic diff_q;

    always_comb begin
        pwm_bit  = diff_q ^ next_bit;
        idle_out = diff_q;
    end
`else
    always_comb begin
        pwm_bit  = next_bit;
        idle_out = IDLE_BIT;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            read      <= 1'b0;
            underrun  <= 1'b0;
            busy      <= 1'b0;
            symb_clk  <= 1'b0;
            pwm       <= IDLE_BIT;
            shift_reg <= '0;
            div       <= '0;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
`ifdef PSK_DIFF_ENCODE_EN
            diff_q    <= IDLE_BIT;
`endif
        end else begin
            read     <= 1'b0;
            underrun <= 1'b0;
            if (load) begin
                state     <= RUN;
                read      <= 1'b1;
                busy      <= 1'b1;
                symb_clk  <= ~symb_clk;
                shift_reg <= sample;
                div       <= div_load;
                clk_cnt   <= '0;
                bit_cnt   <= '0;
                pwm       <= pwm_bit;
`ifdef PSK_DIFF_ENCODE_EN
                diff_q    <= pwm_bit;
`endif
            end else if (enable) begin
                case (state)
                    IDLE: begin
                    end
                    RUN: begin
                        if (sym_end) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            underrun <= 1'b1;
                            clk_cnt  <= '0;
                            bit_cnt  <= '0;
                            pwm      <= idle_out;
                        end else if (bit_end) begin
                            clk_cnt   <= '0;
                            bit_cnt   <= bit_cnt + BIT_CNT_WIDTH'(1);
                            shift_reg <= shift_next;
                            pwm       <= pwm_bit;
`ifdef PSK_DIFF_ENCODE_EN
                            diff_q    <= pwm_bit;
`endif
                        end else begin
                            clk_cnt <= clk_cnt + DIV_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pwm   <= idle_out;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psk_serializer.sv
// Self-checking bench for psk_serializer: LSB-first 8-bit instance with a FIFO model and
// pwm scoreboard, plus an MSB-first 4-bit instance for short-symbol checks.
module tb_psk_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] clks_per_bit;
    logic [7:0]  sample;
    logic        empty;
    logic        read, pwm, symb_clk, busy, underrun;

    logic [15:0] cpb2;
    logic [7:0]  sample2;
    logic        empty2;
    logic        read2, pwm2, symb_clk2, busy2, underrun2;

    int checks = 0;
    int passed = 0;

    logic [7:0] fifo[$];
    logic       exp_q[$];
    logic       model_d = 1'b0;
    logic       exp_sym = 1'b0;
    logic       last_exp = 1'b0;
    int         cyc = 0;
    int         reads = 0;
    int         unders = 0;
    int         busy_cnt = 0;
    int         last_read_cyc = 0;
    int         prev_read_cyc = 0;

    typedef struct {
        logic [7:0]  word;
        logic [15:0] cpb;
        logic [7:0]  seq;   // bits in transmission order, first bit in [7]
        int          len;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    psk_serializer #(
        .SAMPLE_WIDTH(8), .BITS_PER_SYMBOL(8), .CLK_DIV_WIDTH(16), .MSB_FIRST(0), .IDLE_LEVEL(0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clks_per_bit(clks_per_bit),
        .sample(sample), .empty(empty), .read(read), .pwm(pwm),
        .symb_clk(symb_clk), .busy(busy), .underrun(underrun)
    );

    psk_serializer #(
        .SAMPLE_WIDTH(8), .BITS_PER_SYMBOL(4), .CLK_DIV_WIDTH(16), .MSB_FIRST(1), .IDLE_LEVEL(0)
    ) dut_msb (
        .clk(clk), .rst(rst), .enable(enable), .clks_per_bit(cpb2),
        .sample(sample2), .empty(empty2), .read(read2), .pwm(pwm2),
        .symb_clk(symb_clk2), .busy(busy2), .underrun(underrun2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic idle_pwm();
`ifdef PSK_DIFF_ENCODE_EN
        return model_d;
`else
        return 1'b0;
`endif
    endfunction

    // Expected pwm per enabled busy cycle for one word
    task automatic push_word(input logic [7:0] w, input logic [7:0] seq, input int div);
        logic b;
        fifo.push_back(w);
        for (int i = 7; i >= 0; i--) begin
            b = seq[i];
`ifdef PSK_DIFF_ENCODE_EN
            model_d = model_d ^ b;
            b = model_d;
`endif
            for (int k = 0; k < div; k++) exp_q.push_back(b);
        end
        empty  = 1'b0;
        sample = fifo[0];
    endtask

    task automatic cycle();
        logic e;
        @(negedge clk);
        cyc++;
        if (busy) busy_cnt++;
        if (underrun) unders++;
        if (read) begin
            reads++;
            prev_read_cyc = last_read_cyc;
            last_read_cyc = cyc;
            exp_sym = ~exp_sym;
            chk("symb_clk_toggle", symb_clk, exp_sym);
            chk("busy_with_read", busy, 1);
        end
        if (busy && enable) begin
            if (exp_q.size() == 0) begin
                chk("pwm_unexpected_busy", busy, 0);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                chk("pwm_bit", pwm, e);
            end
        end
        if (read) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            else chk("pop_while_empty", read, 0);
        end
        empty  = (fifo.size() == 0);
        sample = empty ? 8'h00 : fifo[0];
    endtask

    task automatic run_until_idle(input string tag, input int mark, input int exp_len);
        int g;
        g = 0;
        while (!busy && g < 40) begin cycle(); g++; end
        g = 0;
        while (busy && g < 2000) begin cycle(); g++; end
        chk({tag, "_busy_fell"}, busy, 0);
        chk({tag, "_underrun"}, underrun, 1);
        chk({tag, "_idle_pwm"}, pwm, idle_pwm());
        chk({tag, "_len"}, busy_cnt - mark, exp_len);
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int mark, r0, u0, g;
        logic [3:0] seq2;

        vecs[0] = '{word: 8'hA5, cpb: 16'd4, seq: 8'b10100101, len: 32};
        vecs[1] = '{word: 8'h0D, cpb: 16'd1, seq: 8'b10110000, len: 8};
        vecs[2] = '{word: 8'h3C, cpb: 16'd3, seq: 8'b00111100, len: 24};
        vecs[3] = '{word: 8'h80, cpb: 16'd0, seq: 8'b00000001, len: 8};

        rst = 1'b1; enable = 1'b1; clks_per_bit = 16'd4; sample = '0; empty = 1'b1;
        cpb2 = '0; sample2 = '0; empty2 = 1'b1;
        cycle();
        cycle();
        chk("rst_read", read, 0);
        chk("rst_pwm", pwm, 0);
        chk("rst_symb_clk", symb_clk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_msb_pwm", pwm2, 0);
        chk("rst_msb_busy", busy2, 0);
        rst = 1'b0;
        cycle();

        // Single words with an empty FIFO behind them
        for (int i = 0; i < 4; i++) begin
            mark = busy_cnt; r0 = reads; u0 = unders;
            clks_per_bit = vecs[i].cpb;
            push_word(vecs[i].word, vecs[i].seq, (vecs[i].cpb == 0) ? 1 : int'(vecs[i].cpb));
            run_until_idle($sformatf("vec%0d", i), mark, vecs[i].len);
            chk($sformatf("vec%0d_reads", i), reads - r0, 1);
            chk($sformatf("vec%0d_underruns", i), unders - u0, 1);
            cycle();
            chk($sformatf("vec%0d_underrun_pulse", i), underrun, 0);
        end
        chk("symb_clk_after_vecs", symb_clk, 0);

        // Back-to-back words: no gap, second pop 16 clocks after the first
        mark = busy_cnt; r0 = reads; u0 = unders;
        clks_per_bit = 16'd2;
        push_word(8'hFF, 8'b11111111, 2);
        push_word(8'h00, 8'b00000000, 2);
        run_until_idle("b2b", mark, 32);
        chk("b2b_reads", reads - r0, 2);
        chk("b2b_read_gap", last_read_cyc - prev_read_cyc, 16);
        chk("b2b_underruns", unders - u0, 1);
        chk("b2b_symb_clk", symb_clk, 0);

        // MSB-first, 4 bits, clks_per_bit=0 -> one clock per bit
        cycle();
        sample2 = 8'hC3; empty2 = 1'b0;
        g = 0;
        while (!read2 && g < 10) begin cycle(); g++; end
        chk("msb_read", read2, 1);
        empty2 = 1'b1;
`ifdef PSK_DIFF_ENCODE_EN
        seq2 = 4'b1000;
`else
        seq2 = 4'b1100;
`endif
        chk("msb_bit0", pwm2, seq2[3]);
        chk("msb_symb_clk", symb_clk2, 1);
        for (int i = 2; i >= 0; i--) begin
            cycle();
            chk($sformatf("msb_bit%0d", 3 - i), pwm2, seq2[i]);
            chk("msb_busy", busy2, 1);
        end
        cycle();
        chk("msb_busy_fell", busy2, 0);
        chk("msb_underrun", underrun2, 1);
        chk("msb_idle_pwm", pwm2, 0);

        // Freeze 5 clocks in bit 1; a mid-symbol clks_per_bit change must not apply
        mark = busy_cnt; r0 = reads; u0 = unders;
        clks_per_bit = 16'd3;
        push_word(8'h55, 8'b10101010, 3);
        g = 0;
        while (!read && g < 10) begin cycle(); g++; end
        chk("frz_read", read, 1);
        clks_per_bit = 16'd7;
        for (int i = 0; i < 4; i++) cycle();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("frz_no_read", read, 0);
            chk("frz_no_underrun", underrun, 0);
            chk("frz_pwm_hold", pwm, last_exp);
        end
        enable = 1'b1;
        run_until_idle("frz", mark, 29);
        chk("frz_reads", reads - r0, 1);
        chk("frz_underruns", unders - u0, 1);

        // Reset during bit 3 aborts the symbol
        cycle();
        r0 = reads; u0 = unders;
        clks_per_bit = 16'd2;
        push_word(8'hA5, 8'b10100101, 2);
        g = 0;
        while (!read && g < 10) begin cycle(); g++; end
        chk("rst_mid_read", read, 1);
        for (int i = 0; i < 6; i++) cycle();
        rst = 1'b1;
        cycle();
        chk("rst_mid_pwm", pwm, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_symb_clk", symb_clk, 0);
        chk("rst_mid_underrun", underrun, 0);
        rst = 1'b0;
        exp_q.delete();
        model_d = 1'b0;
        exp_sym = 1'b0;
        cycle();
        chk("rst_mid_no_underrun", unders - u0, 0);
        chk("rst_mid_reads", reads - r0, 1);
        mark = busy_cnt;
        push_word(8'h0D, 8'b10110000, 2);
        run_until_idle("post_rst", mark, 16);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/psk_serializer.md
Name: psk_serializer

Overview:
Parametrised next-generation PSK bit serializer. It pops samples from a first-word-fall-through FIFO and shifts out BITS_PER_SYMBOL bits per sample on a single-bit line, holding each bit for a runtime-programmable number of clocks. Bit order and idle level are selectable. It reports busy and underrun status and emits a symbol strobe. It sits between the sample FIFO and the RF output pin driver.

Parameters:
SAMPLE_WIDTH, 8, width of FIFO word.
BITS_PER_SYMBOL, 8, bits serialized per sample; range 1..SAMPLE_WIDTH; only the low BITS_PER_SYMBOL bits (LSB-first) or the top BITS_PER_SYMBOL bits (MSB-first) are sent.
CLK_DIV_WIDTH, 16, width of clks_per_bit input.
MSB_FIRST, 0, 1 = shift MSB first, 0 = LSB first.
IDLE_LEVEL, 0, pwm level while idle and after reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  clock enable; 0 freezes all state
clks_per_bit  in  CLK_DIV_WIDTH  clocks per bit; latched at each symbol load; 0 treated as 1
sample  in  SAMPLE_WIDTH  FIFO head word, valid when empty=0
empty  in  1  FIFO empty
read  out  1  one-cycle FIFO pop strobe
pwm  out  1  serial bit output
symb_clk  out  1  toggles on every symbol load
busy  out  1  1 while in RUN
underrun  out  1  one-cycle pulse: symbol finished and FIFO empty

Behaviour:
- Reset (rst=1 at posedge, regardless of enable): state=IDLE; read=0; pwm=IDLE_LEVEL; symb_clk=0; busy=0; underrun=0; counters=0; shift reg=0. Reset mid-symbol aborts the symbol with no pop.
- read and underrun default to 0 every cycle. They are never high for more than 1 cycle per event.
- enable=0: counters, shift reg, state, pwm and symb_clk hold; read=0; underrun=0.
- State IDLE: if empty=0, then next cycle read=1, shift reg<=sample, div latch<=max(clks_per_bit,1), bit_cnt=0, clk_cnt=0, symb_clk toggles, state=RUN. pwm shows the first bit from that same cycle (registered output, 1-cycle latency from the load decision).
- State RUN: clk_cnt counts 0..div-1. At div-1, clk_cnt=0 and the shift reg shifts by one: right for LSB-first, left for MSB-first, with zero fill. bit_cnt increments.
- End of symbol: bit_cnt=BITS_PER_SYMBOL-1 and clk_cnt=div-1.
  - If empty=0: back-to-back load, with the same actions as the IDLE load and no gap cycle. Every bit lasts exactly div clocks.
  - If empty=1: state=IDLE, pwm=IDLE_LEVEL, underrun=1 for one cycle, busy=0.
- pwm = shift_reg[0] (LSB-first) or shift_reg[SAMPLE_WIDTH-1] (MSB-first) in RUN.
- Changes to clks_per_bit mid-symbol have no effect until the next load.
- Symbol duration = BITS_PER_SYMBOL × div enabled clocks.
- Counter widths: clk_cnt is CLK_DIV_WIDTH. bit_cnt is $clog2(BITS_PER_SYMBOL)+1 so that BITS_PER_SYMBOL=1 is legal.
- Illegal state encodings return to IDLE.

Optional Feature:
PSK_DIFF_ENCODE_EN
- Defined: pwm carries differentially encoded data. A diff register d (reset to IDLE_LEVEL) updates d <= d ^ data_bit at the start of every bit, and pwm=d.
  - In IDLE, pwm holds the last d instead of returning to IDLE_LEVEL.
  - d is not cleared by underrun, only by rst.
- Undefined: pwm is the raw data bit as above, and no d register exists.

Test Plan:
1. Defaults, clks_per_bit=4, one word 0xA5 then empty -> read pulses once. pwm=1,0,1,0,0,1,0,1, each held 4 clocks (32 clocks total). Then pwm=0, underrun pulse, busy falls, symb_clk=1.
2. Back-to-back 0xFF, 0x00 with clks_per_bit=2 -> second read exactly 16 clocks after the first. pwm high 16 clocks then low 16 clocks, no gap. symb_clk toggles twice.
3. clks_per_bit=0, MSB_FIRST=1, BITS_PER_SYMBOL=4, word 0xC3 -> pwm=1,1,0,0, one clock each.
4. enable held low for 5 clocks mid-bit (clks_per_bit=3) -> that bit lasts 8 clocks. No read or underrun during the freeze; later bits last 3 clocks.
5. rst asserted in bit 3 of 0xA5 -> next cycle pwm=IDLE_LEVEL, busy=0, symb_clk=0, no underrun. A new word after rst is sent from bit 0.
6. PSK_DIFF_ENCODE_EN, clks_per_bit=1, word 0x0D LSB-first -> data bits 1,0,1,1,0,0,0,0 give pwm=1,1,0,1,1,1,1,1. pwm stays 1 in IDLE.
